// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with the MEM-stage
// data-memory interface, the write-back data select and forwarding taps.
//
// Optional feature macro: PIPE_RETIRE_CNT_EN (adds retire_cnt output).
//
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   ex_*                    instruction presented by EX (control, rd, data)
//   ex_flush                kill the instruction entering EX/MEM
//   mem_stall               data memory not ready; hold EX/MEM, bubble MEM/WB
//   mem_rdata               combinational data-memory read data
//   dmem_addr/wdata/re/we   data-memory request from EX/MEM
//   fwd_rd1/data1/ld1       EX/MEM forwarding tap (rd is 0 unless it writes)
//   fwd_rd2/data2           MEM/WB forwarding tap
//   wb_reg_write/rd/data    register-file write port
//   retire_cnt              instructions entering MEM/WB (PIPE_RETIRE_CNT_EN)
module ex_mem_wb_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_flush,
  input  logic            mem_stall,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [4:0]      fwd_rd1,
  output logic [XLEN-1:0] fwd_data1,
  output logic            fwd_ld1,
  output logic [4:0]      fwd_rd2,
  output logic [XLEN-1:0] fwd_data2,
`ifdef PIPE_RETIRE_CNT_EN
  output logic [31:0]     retire_cnt,
`endif
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned RW = 5;

  // EX/MEM stage registers
  logic            em_valid;
  logic            em_reg_write;
  logic            em_mem_read;
  logic            em_mem_write;
  logic            em_mem_to_reg;
  logic [RW-1:0]   em_rd;
  logic [XLEN-1:0] em_alu;
  logic [XLEN-1:0] em_rs2;

  // MEM/WB stage registers
  logic            mw_valid;
  logic            mw_reg_write;
  logic [RW-1:0]   mw_rd;
  logic [XLEN-1:0] mw_data;

  // Qualified capture: a flushed/invalid entry carries no side effects,
  // and x0 is never marked as written.
  logic            cap_valid;
  logic [XLEN-1:0] wb_sel;

  assign cap_valid = ex_valid & ~ex_flush;
  assign wb_sel    = em_mem_to_reg ? mem_rdata : em_alu;

  // EX/MEM: holds while memory stalls; stall wins over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      em_valid      <= 1'b0;
      em_reg_write  <= 1'b0;
      em_mem_read   <= 1'b0;
      em_mem_write  <= 1'b0;
      em_mem_to_reg <= 1'b0;
      em_rd         <= '0;
      em_alu        <= '0;
      em_rs2        <= '0;
    end else if (!mem_stall) begin
      em_valid      <= cap_valid;
      em_reg_write  <= cap_valid & ex_reg_write & (ex_rd != RW'(0));
      em_mem_read   <= cap_valid & ex_mem_read;
      em_mem_write  <= cap_valid & ex_mem_write;
      em_mem_to_reg <= ex_mem_to_reg;
      em_rd         <= ex_rd;
      em_alu        <= ex_alu_result;
      em_rs2        <= ex_rs2_data;
    end
  end

  // MEM/WB: a stalled cycle inserts a bubble so nothing writes back twice.
  always_ff @(posedge clk) begin
    if (!rst_n || mem_stall) begin
      mw_valid     <= 1'b0;
      mw_reg_write <= 1'b0;
      mw_rd        <= '0;
      mw_data      <= '0;
    end else begin
      mw_valid     <= em_valid;
      mw_reg_write <= em_valid & em_reg_write;
      mw_rd        <= em_rd;
      mw_data      <= wb_sel;
    end
  end

`ifdef PIPE_RETIRE_CNT_EN
  // Counts instructions entering MEM/WB; wraps naturally at 2^32.
  logic [31:0] retire_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (em_valid && !mem_stall) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end
  assign retire_cnt = retire_cnt_q;
`endif

  // MEM-stage memory request; a stalled store keeps dmem_we asserted.
  assign dmem_addr  = em_alu;
  assign dmem_wdata = em_rs2;
  assign dmem_re    = em_valid & em_mem_read;
  assign dmem_we    = em_valid & em_mem_write;

  // Forwarding taps; stage-1 data is the ALU result even for loads.
  assign fwd_rd1   = em_reg_write ? em_rd : RW'(0);
  assign fwd_data1 = em_alu;
  assign fwd_ld1   = em_valid & em_mem_read;
  assign fwd_rd2   = mw_reg_write ? mw_rd : RW'(0);
  assign fwd_data2 = mw_data;

  assign wb_reg_write = mw_reg_write;
  assign wb_rd        = mw_rd;
  assign wb_data      = mw_data;

  // mw_valid is kept for visibility of retired bubbles vs. instructions.
  logic unused_ok;
  assign unused_ok = mw_valid;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic        ex_flush, mem_stall;
  logic [31:0] mem_rdata;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_re, dmem_we;
  logic [4:0]  fwd_rd1, fwd_rd2, wb_rd;
  logic [31:0] fwd_data1, fwd_data2, wb_data;
  logic        fwd_ld1, wb_reg_write;
`ifdef PIPE_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem_wb_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .fwd_rd1(fwd_rd1), .fwd_data1(fwd_data1), .fwd_ld1(fwd_ld1),
    .fwd_rd2(fwd_rd2), .fwd_data2(fwd_data2),
`ifdef PIPE_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction at the EX boundary.
  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2);
    ex_valid = v; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_mem_to_reg = m2r; ex_rd = rd; ex_alu_result = alu; ex_rs2_data = rs2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    ex_flush = 1'b0; mem_stall = 1'b0;
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); mem_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 32'h66);
    step(); step();
    checks++; if (fwd_rd1 !== 5'd0) begin errors++; $display("FAIL reset_fwd_rd1 got %0d exp 0", fwd_rd1); end
    checks++; if (fwd_data1 !== 32'd0) begin errors++; $display("FAIL reset_fwd_data1 got %h exp 0", fwd_data1); end
    checks++; if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || dmem_re !== 1'b0 || dmem_we !== 1'b0)
      begin errors++; $display("FAIL reset_dmem got addr %h wdata %h re %b we %b exp all 0", dmem_addr, dmem_wdata, dmem_re, dmem_we); end
    checks++; if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || fwd_rd2 !== 5'd0 || fwd_data2 !== 32'd0 || fwd_ld1 !== 1'b0)
      begin errors++; $display("FAIL reset_wb got we %b rd %0d data %h exp all 0", wb_reg_write, wb_rd, wb_data); end
`ifdef PIPE_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d exp 0", retire_cnt); end
`endif
    rst_n = 1'b1;
    step();
    checks++; if (fwd_rd1 !== 5'd3 || fwd_data1 !== 32'h55) begin errors++; $display("FAIL reset_release got rd %0d data %h exp 3 55", fwd_rd1, fwd_data1); end
    idle(); step(); step();
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0);
    step();
    checks++; if (fwd_rd1 !== 5'd5 || fwd_data1 !== 32'h10 || fwd_ld1 !== 1'b0)
      begin errors++; $display("FAIL alu_stage1 got rd %0d data %h ld %b exp 5 10 0", fwd_rd1, fwd_data1, fwd_ld1); end
    idle(); step();
    checks++; if (fwd_rd2 !== 5'd5 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h10 || fwd_data2 !== 32'h10)
      begin errors++; $display("FAIL alu_wb got fwd_rd2 %0d we %b rd %0d data %h exp 5 1 5 10", fwd_rd2, wb_reg_write, wb_rd, wb_data); end
    checks++; if (fwd_rd1 !== 5'd0) begin errors++; $display("FAIL alu_drain got %0d exp 0", fwd_rd1); end
    step();
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0);
    step();
    idle(); mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dmem_re !== 1'b1 || dmem_addr !== 32'h100 || fwd_ld1 !== 1'b1 || dmem_we !== 1'b0)
      begin errors++; $display("FAIL load_mem got re %b addr %h ld %b we %b exp 1 100 1 0", dmem_re, dmem_addr, fwd_ld1, dmem_we); end
    checks++; if (fwd_rd1 !== 5'd7 || fwd_data1 !== 32'h100)
      begin errors++; $display("FAIL load_fwd1 got rd %0d data %h exp 7 100", fwd_rd1, fwd_data1); end
    step();
    mem_rdata = 32'h0;
    checks++; if (wb_data !== 32'hDEADBEEF || fwd_data2 !== 32'hDEADBEEF || wb_rd !== 5'd7 || fwd_rd2 !== 5'd7 || wb_reg_write !== 1'b1)
      begin errors++; $display("FAIL load_wb got data %h fwd2 %h rd %0d exp deadbeef deadbeef 7", wb_data, fwd_data2, wb_rd); end
    step();
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h77, 32'h0);
    step();
    checks++; if (fwd_rd1 !== 5'd0) begin errors++; $display("FAIL x0_fwd_rd1 got %0d exp 0", fwd_rd1); end
    idle(); step();
    checks++; if (wb_reg_write !== 1'b0 || fwd_rd2 !== 5'd0)
      begin errors++; $display("FAIL x0_wb got we %b rd2 %0d exp 0 0", wb_reg_write, fwd_rd2); end
    step();
  endtask

  task automatic test_store_stall();
`ifdef PIPE_RETIRE_CNT_EN
    logic [31:0] cnt0;
    cnt0 = retire_cnt;
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h20, 32'hA5A5A5A5);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h20 || dmem_wdata !== 32'hA5A5A5A5 || wb_reg_write !== 1'b0)
        begin errors++; $display("FAIL store_stall_%0d got we %b addr %h wdata %h wbwe %b exp 1 20 a5a5a5a5 0", i, dmem_we, dmem_addr, dmem_wdata, wb_reg_write); end
      if (i < 3) begin
        idle(); mem_stall = 1'b1;
        step();
      end
    end
    idle(); step();
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL store_release got we %b exp 0", dmem_we); end
`ifdef PIPE_RETIRE_CNT_EN
    checks++; if (retire_cnt - cnt0 !== 32'd1)
      begin errors++; $display("FAIL store_retire got delta %0d exp 1", retire_cnt - cnt0); end
`endif
    step();
  endtask

  task automatic test_stall_alu();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44, 32'h0);
    step();
    idle(); mem_stall = 1'b1;
    step();
    checks++; if (wb_reg_write !== 1'b0 || fwd_rd2 !== 5'd0)
      begin errors++; $display("FAIL stall_bubble got we %b rd2 %0d exp 0 0", wb_reg_write, fwd_rd2); end
    checks++; if (fwd_rd1 !== 5'd4 || fwd_data1 !== 32'h44)
      begin errors++; $display("FAIL stall_hold got rd %0d data %h exp 4 44", fwd_rd1, fwd_data1); end
    mem_stall = 1'b0;
    step();
    checks++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h44)
      begin errors++; $display("FAIL stall_wb got we %b rd %0d data %h exp 1 4 44", wb_reg_write, wb_rd, wb_data); end
    step();
    checks++; if (wb_reg_write !== 1'b0)
      begin errors++; $display("FAIL stall_once got we %b exp 0", wb_reg_write); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h90, 32'h99); ex_flush = 1'b1;
    step();
    checks++; if (fwd_rd1 !== 5'd0 || dmem_we !== 1'b0)
      begin errors++; $display("FAIL flush_kill got rd %0d we %b exp 0 0", fwd_rd1, dmem_we); end
    idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hAA, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'hBB, 32'h0);
    ex_flush = 1'b1; mem_stall = 1'b1;
    step();
    checks++; if (fwd_rd1 !== 5'd10 || fwd_data1 !== 32'hAA)
      begin errors++; $display("FAIL flush_stall got rd %0d data %h exp 10 aa", fwd_rd1, fwd_data1); end
    mem_stall = 1'b0;
    step();
    checks++; if (fwd_rd1 !== 5'd0 || wb_reg_write !== 1'b1 || wb_rd !== 5'd10)
      begin errors++; $display("FAIL flush_after got rd1 %0d wbwe %b wbrd %0d exp 0 1 10", fwd_rd1, wb_reg_write, wb_rd); end
    idle(); step(); step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'(i + 20), 32'(i * 3), 32'h0);
      else idle();
      step();
      checks++; if (fwd_rd1 !== ((i <= 3) ? 5'(i + 20) : 5'd0))
        begin errors++; $display("FAIL b2b_rd1_%0d got %0d", i, fwd_rd1); end
      checks++; if (fwd_rd2 !== ((i >= 2) ? 5'(i + 19) : 5'd0) || (i >= 2 && wb_data !== 32'((i - 1) * 3)))
        begin errors++; $display("FAIL b2b_rd2_%0d got rd %0d data %h", i, fwd_rd2, wb_data); end
    end
    idle(); step();
  endtask

  task automatic test_reset_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'h30, 32'h1234);
    step();
    idle(); mem_stall = 1'b1; ex_flush = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    checks++; if (dmem_we !== 1'b0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0)
      begin errors++; $display("FAIL reset_stall got we %b addr %h wdata %h exp 0 0 0", dmem_we, dmem_addr, dmem_wdata); end
`ifdef PIPE_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_retire got %0d exp 0", retire_cnt); end
`endif
    rst_n = 1'b1; idle(); step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0();
    test_store_stall();
    test_stall_alu();
    test_flush();
    test_back_to_back();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
Two-register pipeline backbone between EX and WB: the EX/MEM and MEM/WB registers plus the MEM-stage data-memory interface and the WB-data select. It produces the per-stage destination register, qualified write-enable and result values that the forwarding unit compares against RS1/RS2. It also produces the forwarding operand data for the EX operand muxes. It supports a memory stall and an EX-stage flush.

Parameters:
XLEN, 32, datapath width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX holds a real instruction
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_to_reg  in  1  WB selects memory data
ex_rd  in  5  destination register
ex_alu_result  in  XLEN  ALU output / memory address
ex_rs2_data  in  XLEN  store data
ex_flush  in  1  kill the instruction entering EX/MEM
mem_stall  in  1  data memory not ready; hold EX/MEM
mem_rdata  in  XLEN  data-memory read data (combinational, valid in MEM)
dmem_addr  out  XLEN  data-memory address
dmem_wdata  out  XLEN  data-memory write data
dmem_re  out  1  data-memory read enable
dmem_we  out  1  data-memory write enable
fwd_rd1  out  5  EX/MEM rd; 0 unless EX/MEM writes a register
fwd_data1  out  XLEN  EX/MEM ALU result
fwd_ld1  out  1  EX/MEM holds a load (for the hazard unit)
fwd_rd2  out  5  MEM/WB rd; 0 unless MEM/WB writes a register
fwd_data2  out  XLEN  MEM/WB write-back value
wb_reg_write  out  1  register-file write enable
wb_rd  out  5  register-file write address
wb_data  out  XLEN  register-file write data

Behaviour:
- Reset: when rst_n=0 at a posedge, clear both stages.
  - valid, all control bits, rd and data registers go to 0.
  - All outputs read 0 the cycle after reset.
  - Reset overrides stall and flush, including while a store is mid-stall.
- Capture qualification: ex_reg_write is stored as ex_reg_write & (ex_rd!=0); x0 is never written or forwarded.
- Invalid entries: when an entry is invalid, its reg_write, mem_read and mem_write are forced to 0.
- Advance (mem_stall=0), on each posedge:
  - EX/MEM <= EX inputs, with valid = ex_valid & ~ex_flush.
  - MEM/WB <= EX/MEM contents.
  - MEM/WB wb value = mem_to_reg ? mem_rdata : alu_result.
- Stall (mem_stall=1):
  - EX/MEM holds its contents.
  - MEM/WB loads a bubble (valid=0, reg_write=0), so no instruction writes back twice.
- Stall and flush in the same cycle: stall wins; EX/MEM holds. Upstream keeps ex_flush asserted until the stall clears.
- Latency: an instruction accepted at edge N appears on fwd_* (stage 1) after N and on wb_*/fwd_*2 after N+1, when there is no stall.
- MEM-stage outputs (combinational from EX/MEM):
  - dmem_addr = alu_result; dmem_wdata = rs2_data.
  - dmem_re = valid & mem_read; dmem_we = valid & mem_write.
  - dmem_we stays high for every stalled cycle; memory commits the write on the cycle mem_stall=0.
- Forwarding outputs:
  - fwd_rd1 = reg_write ? rd : 0 (EX/MEM); fwd_rd2 likewise for MEM/WB.
  - fwd_data1 is the EX/MEM ALU result, even for loads; fwd_ld1 flags loads so the hazard unit stalls.
  - fwd_data2 equals wb_data.
- WB outputs come directly from MEM/WB registers, with no added latency.

Optional Feature:
PIPE_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0], cleared by reset.
  - Increments by 1 on each posedge where MEM/WB becomes valid, i.e. EX/MEM was valid and mem_stall=0.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ex_valid=1, ex_reg_write=1, ex_rd=3 -> all outputs 0; after release, first valid instruction seen at fwd_rd1 one cycle later.
- ALU op: ex_rd=5, ex_alu_result=0x00000010, reg_write=1 -> next cycle fwd_rd1=5, fwd_data1=0x10; following cycle fwd_rd2=5, wb_reg_write=1, wb_rd=5, wb_data=0x10.
- Load: ex_rd=7, ex_mem_read=1, ex_mem_to_reg=1, ex_alu_result=0x100, mem_rdata=0xDEADBEEF -> dmem_re=1, dmem_addr=0x100, fwd_ld1=1; next cycle wb_data=fwd_data2=0xDEADBEEF.
- x0 write: ex_rd=0, ex_reg_write=1 -> fwd_rd1=0, then wb_reg_write=0, fwd_rd2=0.
- Store under stall: store addr 0x20, data 0xA5A5A5A5, then mem_stall=1 for 3 cycles -> dmem_we=1 with stable addr/data for 4 cycles; MEM/WB bubbles (wb_reg_write=0); retire_cnt (if enabled) increments exactly once.
- Flush: ex_valid=1, ex_flush=1, rd=9 -> fwd_rd1=0, dmem_we=0 next cycle. Flush with mem_stall=1 -> EX/MEM unchanged.
